// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
// Defines FSM states, grant identifiers, timeout limit and the grant picker.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (adds the ERR state).
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCALAR = 2'd1,
      MATRIX = 2'd2
`ifdef MEM_ARB_TIMEOUT_EN
      ,
      ERR    = 2'd3
`endif
   } arb_state_t;

   typedef enum logic {
      SCALAR_G = 1'b0,
      MATRIX_G = 1'b1
   } grant_t;

   localparam int unsigned TIMEOUT_LIMIT = 1023;
   localparam int unsigned TMO_W         = 16;

   // Only meaningful when at least one request is high.
   // On a conflict the side not served last wins.
   function automatic grant_t pick_grant(
      input logic   sreq,
      input logic   mreq,
      input grant_t last
   );
      grant_t g;
      if (sreq && mreq)
         g = (last == MATRIX_G) ? SCALAR_G : MATRIX_G;
      else if (sreq)
         g = SCALAR_G;
      else
         g = MATRIX_G;
      return g;
   endfunction

endpackage

// File: rtl/mem_arb_addr_gen.sv
// mem_arb_addr_gen: strided burst address accumulator.
// Ports: CLK/RST (sync active-high), start loads base/stride,
// advance adds the latched stride, addr is the current beat address.
module mem_arb_addr_gen #(
   parameter int ADDR_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic              advance,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] stride,
   output logic [ADDR_W-1:0] addr
);

   logic [ADDR_W-1:0] stride_q;

   // Plain modular addition: crossing 2^ADDR_W wraps silently.
   always_ff @(posedge CLK) begin
      if (RST) begin
         addr     <= '0;
         stride_q <= '0;
      end else if (start) begin
         addr     <= base;
         stride_q <= stride;
      end else if (advance) begin
         addr     <= addr + stride_q;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (scalar / matrix burst) single-port memory arbiter.
// Ports: CLK/RST (sync active-high); sls_* scalar request/done/rdata;
// mls_* burst request, beat ack, done, rdata; mem_* memory strobes/address/data/hit;
// arb_err sticky timeout flag, present only with macro MEM_ARB_TIMEOUT_EN.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int BEAT_W = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              sls_req,
   input  logic              sls_wen,
   input  logic [ADDR_W-1:0] sls_addr,
   input  logic [DATA_W-1:0] sls_wdata,
   output logic              sls_done,
   output logic [DATA_W-1:0] sls_rdata,
   input  logic              mls_req,
   input  logic              mls_wen,
   input  logic [ADDR_W-1:0] mls_base,
   input  logic [ADDR_W-1:0] mls_stride,
   input  logic [BEAT_W-1:0] mls_beats,
   input  logic [DATA_W-1:0] mls_wdata,
   output logic              mls_beat_ack,
   output logic [DATA_W-1:0] mls_rdata,
   output logic              mls_done,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_hit
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   output logic              arb_err
`endif
);

   arb_state_t        state;
   arb_state_t        state_nxt;
   grant_t            last_grant;
   logic              op_wen;
   logic [BEAT_W-1:0] beats_q;
   logic [BEAT_W-1:0] beat_idx;
   logic              any_req;
   logic              grant_s;
   logic              grant_m;
   logic              hit_m;
   logic              last_beat;
   logic [ADDR_W-1:0] burst_addr;

   assign any_req = sls_req | mls_req;

   assign grant_s = (state == IDLE) && any_req &&
                    (pick_grant(sls_req, mls_req, last_grant) == SCALAR_G);

   assign grant_m = (state == IDLE) && any_req &&
                    (pick_grant(sls_req, mls_req, last_grant) == MATRIX_G);

   assign hit_m = (state == MATRIX) && mem_hit;

   // A latched beat count of zero behaves as a single beat.
   assign last_beat = (beats_q == '0) ||
                      (beat_idx == beats_q - BEAT_W'(1));

`ifdef MEM_ARB_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt;
   logic             busy;
   logic             tmo_hit;

   assign busy    = (state == SCALAR) || (state == MATRIX);
   assign tmo_hit = busy && !mem_hit &&
                    (tmo_cnt == TMO_W'(TIMEOUT_LIMIT - 1));

   always_ff @(posedge CLK) begin
      if (RST)
         tmo_cnt <= '0;
      else if (!busy || mem_hit)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + TMO_W'(1);
   end

   assign arb_err = (state == ERR);
`endif

   // State register.
   always_ff @(posedge CLK) begin
      if (RST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (grant_s)
               state_nxt = SCALAR;
            else if (grant_m)
               state_nxt = MATRIX;
         end
         SCALAR: begin
            if (mem_hit)
               state_nxt = IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
            else if (tmo_hit)
               state_nxt = ERR;
`endif
         end
         MATRIX: begin
            if (mem_hit && last_beat)
               state_nxt = IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
            else if (tmo_hit)
               state_nxt = ERR;
`endif
         end
`ifdef MEM_ARB_TIMEOUT_EN
         ERR:     state_nxt = ERR;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Per-grant context, captured on the IDLE grant edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         last_grant <= MATRIX_G;
         op_wen     <= 1'b0;
         beats_q    <= '0;
         beat_idx   <= '0;
      end else if (grant_s) begin
         last_grant <= SCALAR_G;
         op_wen     <= sls_wen;
      end else if (grant_m) begin
         last_grant <= MATRIX_G;
         op_wen     <= mls_wen;
         beats_q    <= mls_beats;
         beat_idx   <= '0;
      end else if (hit_m) begin
         beat_idx   <= last_beat ? '0 : beat_idx + BEAT_W'(1);
      end
   end

   mem_arb_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .CLK     (CLK),
      .RST     (RST),
      .start   (grant_m),
      .advance (hit_m),
      .base    (mls_base),
      .stride  (mls_stride),
      .addr    (burst_addr)
   );

   // Output logic: everything zero outside the owning grant state.
   always_comb begin
      mem_ren      = 1'b0;
      mem_wen      = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      sls_done     = 1'b0;
      sls_rdata    = '0;
      mls_beat_ack = 1'b0;
      mls_rdata    = '0;
      mls_done     = 1'b0;
      unique case (state)
         SCALAR: begin
            mem_ren   = !op_wen;
            mem_wen   = op_wen;
            mem_addr  = sls_addr;
            mem_wdata = sls_wdata;
            sls_done  = mem_hit;
            sls_rdata = mem_hit ? mem_rdata : '0;
         end
         MATRIX: begin
            mem_ren      = !op_wen;
            mem_wen      = op_wen;
            mem_addr     = burst_addr;
            mem_wdata    = mls_wdata;
            mls_beat_ack = mem_hit;
            mls_rdata    = mem_hit ? mem_rdata : '0;
            mls_done     = mem_hit && last_beat;
         end
         default: begin
            mem_ren = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter.
// Expected memory accesses are queued at stimulus time and popped on each mem_hit.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam logic [31:0] RMASK = 32'hDEADBFEF;

  typedef struct {
    bit          s;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          last;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        sls_req = 0, sls_wen = 0;
  logic [31:0] sls_addr = 0, sls_wdata = 0;
  logic        sls_done;
  logic [31:0] sls_rdata;
  logic        mls_req = 0, mls_wen = 0;
  logic [31:0] mls_base = 0, mls_stride = 0;
  logic [7:0]  mls_beats = 0;
  logic [31:0] mls_wdata = 0;
  logic        mls_beat_ack, mls_done;
  logic [31:0] mls_rdata;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic        mem_hit = 0;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        arb_err;
`endif

  exp_t sb[$];
  int vecs = 0, errs = 0;
  int lat = 1, wcnt = 0, ren_cycles = 0;
  int n_sdone = 0, n_mack = 0, n_mdone = 0;
  int s_left = 0, m_left = 0, mbeat = 0;
  bit s_seen = 0, m_seen = 0, m_last_seen = 0;
  bit chk_gap = 0, gap_armed = 0, prev_strobe = 0;
  int gap = 0;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .sls_req(sls_req), .sls_wen(sls_wen), .sls_addr(sls_addr),
    .sls_wdata(sls_wdata), .sls_done(sls_done), .sls_rdata(sls_rdata),
    .mls_req(mls_req), .mls_wen(mls_wen), .mls_base(mls_base),
    .mls_stride(mls_stride), .mls_beats(mls_beats), .mls_wdata(mls_wdata),
    .mls_beat_ack(mls_beat_ack), .mls_rdata(mls_rdata), .mls_done(mls_done),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_hit(mem_hit)
`ifdef MEM_ARB_TIMEOUT_EN
    , .arb_err(arb_err)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Memory model + scoreboard checker, evaluated mid-cycle.
  always @(negedge CLK) begin
    exp_t e;
    logic strobe;
    strobe = mem_ren | mem_wen;
    mem_hit = 1'b0;
    if (chk_gap && gap_armed && strobe && !prev_strobe)
      chk("idle_gap", 64'(gap), 64'(1));
    if (!strobe) gap++;
    prev_strobe = strobe;
    if (strobe) begin
      if (mem_ren) ren_cycles++;
      if (wcnt >= lat - 1) begin
        mem_hit = 1'b1;
        wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
    mem_rdata = mem_addr ^ RMASK;
    #1;
    if (mem_hit) begin
      gap = 0;
      gap_armed = 1;
      if (sb.size() == 0) chk("unexp_access", 64'(sb.size()), 64'(1));
      else begin
        e = sb.pop_front();
        chk("addr", 64'(mem_addr), 64'(e.addr));
        chk("strobe", 64'({mem_ren, mem_wen}), 64'({~e.wen, e.wen}));
        if (e.wen) chk("wdata", 64'(mem_wdata), 64'(e.wdata));
        chk("grant", 64'({sls_done, mls_beat_ack}), 64'({e.s, ~e.s}));
        if (e.s) begin
          if (!e.wen) chk("sls_rdata", 64'(sls_rdata), 64'(e.addr ^ RMASK));
          n_sdone++;
          s_seen = 1;
        end else begin
          chk("mls_done", 64'(mls_done), 64'(e.last));
          if (!e.wen) chk("mls_rdata", 64'(mls_rdata), 64'(e.addr ^ RMASK));
          n_mack++;
          if (e.last) n_mdone++;
          m_seen = 1;
          m_last_seen = e.last;
        end
      end
    end else begin
      chk("no_hit_pulse", 64'({sls_done, mls_beat_ack, mls_done}), 64'(0));
    end
  end

  // Requester models: drop request after last done, advance store data per ack.
  always @(posedge CLK) begin
    #1;
    if (s_seen) begin
      s_seen = 0;
      if (s_left > 0) s_left--;
      if (s_left == 0) sls_req = 0;
    end
    if (m_seen) begin
      m_seen = 0;
      mbeat++;
      if (m_last_seen) begin
        mbeat = 0;
        if (m_left > 0) m_left--;
        if (m_left == 0) mls_req = 0;
      end
    end
    mls_wdata = 32'h5000_0000 + 32'(mbeat);
  end

  task automatic wait_cnt(input string tag, input int sel, input int target);
    int k;
    int cur;
    k = 0;
    cur = (sel == 0) ? n_sdone : (sel == 1) ? n_mdone : n_mack;
    while (cur < target && k < 400) begin
      @(posedge CLK); #2;
      k++;
      cur = (sel == 0) ? n_sdone : (sel == 1) ? n_mdone : n_mack;
    end
    chk(tag, 64'(cur), 64'(target));
  endtask

  task automatic push_s(input bit wen, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.s = 1; e.wen = wen; e.addr = a; e.wdata = d; e.last = 1;
    sb.push_back(e);
  endtask

  task automatic push_m(input bit wen, input logic [31:0] b, input logic [31:0] st,
                        input int beats);
    exp_t e;
    int n;
    n = (beats == 0) ? 1 : beats;
    for (int i = 0; i < n; i++) begin
      e.s = 0; e.wen = wen;
      e.addr = b + st * 32'(i);
      e.wdata = 32'h5000_0000 + 32'(i);
      e.last = (i == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic scalar_op(input bit wen, input logic [31:0] a,
                           input logic [31:0] d, input int l);
    int t;
    lat = l;
    push_s(wen, a, d);
    t = n_sdone + 1;
    @(posedge CLK); #2;
    sls_wen = wen; sls_addr = a; sls_wdata = d;
    s_left = 1; sls_req = 1;
    wait_cnt("sls_done_cnt", 0, t);
  endtask

  task automatic matrix_op(input bit wen, input logic [31:0] b, input logic [31:0] st,
                           input int beats, input int l);
    int t;
    lat = l;
    push_m(wen, b, st, beats);
    t = n_mdone + 1;
    @(posedge CLK); #2;
    mls_wen = wen; mls_base = b; mls_stride = st; mls_beats = 8'(beats);
    mbeat = 0; m_left = 1; mls_req = 1;
    wait_cnt("mls_done_cnt", 1, t);
  endtask

  initial begin
    int a0, s0, m0;
    RST = 1;
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_strobes", 64'({mem_ren, mem_wen}), 64'(0));
    chk("rst_addr", 64'(mem_addr), 64'(0));
    chk("rst_done", 64'({sls_done, mls_beat_ack, mls_done}), 64'(0));
`ifdef MEM_ARB_TIMEOUT_EN
    chk("rst_err", 64'(arb_err), 64'(0));
`endif
    RST = 0;

    // Scalar load, 3-cycle latency.
    ren_cycles = 0;
    s0 = n_sdone;
    scalar_op(0, 32'h100, 32'h0, 3);
    chk("idle_next", 64'({mem_ren, mem_wen}), 64'(0));
    chk("ren_cycles", 64'(ren_cycles), 64'(3));
    repeat (3) @(posedge CLK);
    #2;
    chk("sdone_once", 64'(n_sdone - s0), 64'(1));

    // Scalar store, single-cycle.
    scalar_op(1, 32'h200, 32'h1234_5678, 1);

    // Matrix load, four beats every cycle.
    a0 = n_mack;
    matrix_op(0, 32'h1000, 32'h40, 4, 1);
    chk("mack_cnt", 64'(n_mack - a0), 64'(4));

    // Matrix store, slow memory.
    matrix_op(1, 32'h2000, 32'h4, 3, 2);

    // Address wrap and zero-beat burst.
    matrix_op(0, 32'hFFFF_FFC0, 32'h40, 2, 1);
    a0 = n_mack;
    matrix_op(1, 32'h3000, 32'h8, 0, 1);
    chk("zero_beats", 64'(n_mack - a0), 64'(1));

    // Both requests held from reset: strict alternation.
    @(posedge CLK); #2;
    RST = 1; lat = 1;
    push_s(0, 32'h400, 0);
    push_m(0, 32'h500, 32'h8, 2);
    push_s(0, 32'h400, 0);
    push_m(0, 32'h500, 32'h8, 2);
    sls_wen = 0; sls_addr = 32'h400;
    mls_wen = 0; mls_base = 32'h500; mls_stride = 32'h8; mls_beats = 8'd2;
    s_left = 2; m_left = 2; mbeat = 0;
    sls_req = 1; mls_req = 1;
    chk_gap = 1; gap_armed = 0;
    s0 = n_sdone; m0 = n_mdone;
    @(posedge CLK); #2;
    RST = 0;
    wait_cnt("alt_sdone", 0, s0 + 2);
    wait_cnt("alt_mdone", 1, m0 + 2);
    chk_gap = 0;
    chk("alt_sb_empty", 64'(sb.size()), 64'(0));

    // Reset during beat 2 of 4, scalar pending.
    @(posedge CLK); #2;
    lat = 3;
    push_m(0, 32'h6000, 32'h10, 1);
    sb[sb.size()-1].last = 0;
    push_s(0, 32'h700, 0);
    push_m(0, 32'h6000, 32'h10, 4);
    a0 = n_mack; m0 = n_mdone;
    mls_wen = 0; mls_base = 32'h6000; mls_stride = 32'h10; mls_beats = 8'd4;
    mbeat = 0; m_left = 1; mls_req = 1;
    wait_cnt("rst_beat0", 2, a0 + 1);
    RST = 1;
    sls_wen = 0; sls_addr = 32'h700; s_left = 1; sls_req = 1;
    @(posedge CLK); #1;
    RST = 0; mbeat = 0;
    chk("rst_mid_strobes", 64'({mem_ren, mem_wen}), 64'(0));
    chk("rst_no_mdone", 64'(n_mdone), 64'(m0));
    s0 = n_sdone;
    wait_cnt("rst_scalar_wins", 0, s0 + 1);
    chk("rst_mack_before", 64'(n_mack), 64'(a0 + 1));
    wait_cnt("rst_reburst", 1, m0 + 1);

`ifdef MEM_ARB_TIMEOUT_EN
    // No hit at all: timeout into the sticky error state.
    @(posedge CLK); #2;
    lat = 100000;
    push_s(0, 32'h800, 0);
    sls_wen = 0; sls_addr = 32'h800; s_left = 1; sls_req = 1;
    repeat (1000) @(posedge CLK);
    #2;
    chk("err_early", 64'(arb_err), 64'(0));
    repeat (40) @(posedge CLK);
    #2;
    chk("err_set", 64'(arb_err), 64'(1));
    chk("err_strobes", 64'({mem_ren, mem_wen}), 64'(0));
    sls_req = 0;
    repeat (5) @(posedge CLK);
    #2;
    chk("err_sticky", 64'(arb_err), 64'(1));
    RST = 1;
    @(posedge CLK); #2;
    RST = 0;
    chk("err_clear", 64'(arb_err), 64'(0));
    void'(sb.pop_back());
    lat = 1;
`endif

    repeat (4) @(posedge CLK);
    #2;
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter BEAT_W, default 8, width of the matrix burst beat count.
REQ-004 SHALL have these ports, one line each: name, direction, width, meaning.
- CLK  in  1  clock; all state changes on its rising edge.
- RST  in  1  reset; synchronous, active-high.
- sls_req  in  1  scalar load/store request, held until sls_done.
- sls_wen  in  1  scalar store (1) or load (0).
- sls_addr  in  ADDR_W  scalar address.
- sls_wdata  in  DATA_W  scalar store data.
- sls_done  out  1  one-cycle pulse: scalar access complete.
- sls_rdata  out  DATA_W  scalar load data, valid with sls_done.
- mls_req  in  1  matrix burst request, held until mls_done.
- mls_wen  in  1  matrix store (1) or load (0).
- mls_base  in  ADDR_W  burst base address.
- mls_stride  in  ADDR_W  byte stride between beats.
- mls_beats  in  BEAT_W  number of beats in the burst.
- mls_wdata  in  DATA_W  store data for the current beat.
- mls_beat_ack  out  1  pulse: current beat accepted; the requester advances wdata or captures rdata.
- mls_rdata  out  DATA_W  load data, valid with mls_beat_ack.
- mls_done  out  1  pulse: burst complete.
- mem_ren / mem_wen  out  1 / 1  memory strobes.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory store data.
- mem_rdata  in  DATA_W  memory load data.
- mem_hit  in  1  memory completes the current access this cycle.
- arb_err  out  1  sticky timeout error; present only with MEM_ARB_TIMEOUT_EN.

Function
REQ-005 SHALL implement an FSM with states IDLE, SCALAR and MATRIX, plus ERR when MEM_ARB_TIMEOUT_EN is defined.
REQ-006 In IDLE, strobes SHALL be low and the requests SHALL be sampled: if only one request is high, it is granted.
REQ-007 In IDLE with both requests high, the arbiter SHALL grant the requester not granted last, using a last_grant register (reset = matrix), so scalar wins the first conflict after reset.
REQ-008 On grant, the FSM SHALL move to SCALAR or MATRIX at the next edge, latching the operation type, base, stride and beat count at that edge.
REQ-009 In SCALAR, mem_ren or mem_wen SHALL equal the latched type, mem_addr = sls_addr and mem_wdata = sls_wdata, held until mem_hit.
REQ-010 On mem_hit in SCALAR, the arbiter SHALL pulse sls_done, pass mem_rdata to sls_rdata in the same cycle, and return to IDLE at the next edge.
REQ-011 In MATRIX, mem_addr SHALL equal latched base + beat_idx*stride, computed modulo 2^ADDR_W with wrap-around and no error; mem_wdata = mls_wdata.
REQ-012 On each mem_hit in MATRIX, the arbiter SHALL pulse mls_beat_ack and beat_idx SHALL increment.
REQ-013 On the hit where beat_idx = beats-1, mls_done SHALL pulse together with mls_beat_ack, and the FSM SHALL return to IDLE.
REQ-014 A latched mls_beats of 0 SHALL be treated as 1.
REQ-015 Each grant SHALL be followed by a mandatory one-cycle IDLE bubble.
- A requester SHALL deassert its request the cycle after its done pulse.
- A request still high in IDLE is a new transaction.
REQ-016 A requester dropping its request mid-transaction SHALL be ignored: the transaction completes.
REQ-017 Done and ack outputs SHALL be combinational from state and mem_hit; all other outputs SHALL be zero outside their grant state.

Reset
REQ-018 RST high at an edge SHALL force IDLE, beat_idx=0, last_grant=matrix and arb_err=0.
REQ-019 Mid-operation, a reset SHALL abandon the transaction without a done pulse; strobes SHALL be low in the cycle after the reset edge.

Configuration
REQ-020 When MEM_ARB_TIMEOUT_EN is defined, a 16-bit counter SHALL count cycles in SCALAR/MATRIX without mem_hit, cleared on each hit.
- At 1023 the FSM SHALL enter ERR: strobes low, arb_err=1, no done pulse.
- ERR SHALL be left only by RST.
REQ-021 Without MEM_ARB_TIMEOUT_EN, the counter, the ERR state and the arb_err port SHALL be absent, and waits SHALL be unbounded.

Structure
REQ-022 Package mem_arb_pkg SHALL hold the arb_state_t enum, the grant_t enum (SCALAR_G, MATRIX_G) and the TIMEOUT_LIMIT constant (1023).
REQ-023 Burst address generation SHALL be a sub-module, mem_arb_addr_gen.
- Loads base/stride on a start signal.
- Adds stride on each advance.
- Outputs the current address.
- The strided address SHALL be accumulated, not multiplied.

Verification
REQ-024 Scalar load at 0x100 alone, mem_hit after 3 cycles, rdata 0xDEADBEEF -> sls_done pulses once with sls_rdata=0xDEADBEEF, mem_ren high 3 cycles, IDLE next.
REQ-025 Matrix load base 0x1000, stride 0x40, beats 4, hit every cycle -> mem_addr 0x1000, 0x1040, 0x1080, 0x10C0; 4 beat_acks; mls_done on the 4th.
REQ-026 Both requests held continuously from reset -> grant order scalar, matrix, scalar, matrix, with exactly one IDLE cycle between grants.
REQ-027 Matrix burst base 0xFFFFFFC0, stride 0x40, beats 2 -> addresses 0xFFFFFFC0 then 0x00000000; beats 0 -> single access.
REQ-028 RST asserted during beat 2 of 4 -> no mls_done, strobes low next cycle, then a pending scalar request wins.
REQ-029 With MEM_ARB_TIMEOUT_EN, no mem_hit for 1023 cycles -> arb_err=1, strobes low, held until RST.
